// File: rtl/wb_core_prog_ctrl.sv
// wb_core_prog_ctrl: Wishbone slave that loads multi-beat instructions into
// per-core instruction memories and drives per-core run/step/reset lines.
// It also returns core PCs and a sticky commit-timeout error flag.
module wb_core_prog_ctrl #(
    parameter int CORES       = 4,
    parameter int LOG_CORES   = 2,
    parameter int INSTR_WIDTH = 48,
    parameter int INSTR_DEPTH = 16,
    parameter int LOG_DEPTH   = 4,
    parameter int PC_WIDTH    = 6,
    parameter int WB_WIDTH    = 32,
    parameter int TIMEOUT     = 15
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [WB_WIDTH/8-1:0]     wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [WB_WIDTH-1:0]       wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [WB_WIDTH-1:0]       wbs_dat_o,
    output logic                      prog_valid_o,
    input  logic                      prog_ready_i,
    output logic [LOG_CORES-1:0]      prog_core_o,
    output logic [LOG_DEPTH-1:0]      prog_addr_o,
    output logic [INSTR_WIDTH-1:0]    prog_data_o,
    output logic [CORES-1:0]          core_run_o,
    output logic [CORES-1:0]          core_step_o,
    output logic [CORES-1:0]          core_rst_o,
    input  logic [CORES*PC_WIDTH-1:0] core_pc_i
);

    // Upper instruction bits carried by the second beat.
    localparam int HI_W = INSTR_WIDTH - WB_WIDTH;
    // Counter wide enough to hold TIMEOUT.
    localparam int TCW  = $clog2(TIMEOUT + 1);
    // Zero padding between the error bit and the PC in a status word.
    localparam int PAD_W = WB_WIDTH - 1 - PC_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic [WB_WIDTH-1:0]      dat_q, dat_d;
    logic                     valid_q, valid_d;
    logic [LOG_CORES-1:0]     pcore_q, pcore_d;
    logic [LOG_DEPTH-1:0]     paddr_q, paddr_d;
    logic [INSTR_WIDTH-1:0]   pdata_q, pdata_d;
    logic [WB_WIDTH-1:0]      stage_q, stage_d;
    logic [CORES-1:0]         run_q, run_d;
    logic [CORES-1:0]         step_q, step_d;
    logic [CORES-1:0]         rst_q, rst_d;
    logic                     err_q, err_d;
    logic [TCW-1:0]           tmo_cnt_q, tmo_cnt_d;

    // Address fields, taken straight from the byte address (word address = adr[15:2]).
    logic [1:0]               region;
    logic                     beat;
    logic [LOG_DEPTH-1:0]     instr_idx;
    logic [LOG_CORES-1:0]     instr_core;
    logic [LOG_CORES-1:0]     reg_idx;
    logic                     idx_ok;
    logic                     req;

    assign region     = wbs_adr_i[15:14];
    assign beat       = wbs_adr_i[2];
    assign instr_idx  = wbs_adr_i[LOG_DEPTH+2:3];
    assign instr_core = wbs_adr_i[LOG_CORES+LOG_DEPTH+2:LOG_DEPTH+3];
    assign reg_idx    = wbs_adr_i[LOG_CORES+1:2];
    assign idx_ok     = (int'(reg_idx) < CORES);
    assign req        = wbs_cyc_i & wbs_stb_i;

    // Byte lanes above lane 0 and the high address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i, wbs_sel_i};

    // Per-core PC slices unpacked for indexed status reads.
    logic [PC_WIDTH-1:0] core_pc [CORES];
    for (genvar gi = 0; gi < CORES; gi++) begin : g_pc
        assign core_pc[gi] = core_pc_i[gi*PC_WIDTH +: PC_WIDTH];
    end

    // Next-state logic: request decode, register updates and commit handshake.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        dat_d     = '0;
        valid_d   = valid_q;
        pcore_d   = pcore_q;
        paddr_d   = paddr_q;
        pdata_d   = pdata_q;
        stage_d   = stage_q;
        run_d     = run_q;
        step_d    = '0;
        rst_d     = rst_q;
        err_d     = err_q;
        tmo_cnt_d = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    case (region)
                        2'b00: begin
                            if (wbs_we_i) begin
                                if (!beat) begin
                                    stage_d = wbs_dat_i;
                                end else begin
                                    // Second beat: hold the request until the core takes it.
                                    state_d   = ST_COMMIT;
                                    ack_d     = 1'b0;
                                    valid_d   = 1'b1;
                                    pcore_d   = instr_core;
                                    paddr_d   = instr_idx;
                                    pdata_d   = {wbs_dat_i[HI_W-1:0], stage_q};
                                    tmo_cnt_d = '0;
                                end
                            end
                        end
                        2'b01: begin
                            if (idx_ok) begin
                                if (wbs_we_i) begin
                                    if (wbs_sel_i[0]) begin
                                        run_d[reg_idx]  = wbs_dat_i[0];
                                        rst_d[reg_idx]  = wbs_dat_i[2];
                                        // Step is gated by the run value this write leaves behind.
                                        step_d[reg_idx] = wbs_dat_i[1] & ~wbs_dat_i[0];
                                    end
                                end else begin
                                    dat_d[0] = run_q[reg_idx];
                                    dat_d[2] = rst_q[reg_idx];
                                end
                            end
                        end
                        2'b10: begin
                            if (wbs_we_i) begin
                                if (wbs_dat_i[WB_WIDTH-1]) begin
                                    err_d = 1'b0;
                                end
                            end else begin
                                dat_d = {err_q, {PAD_W{1'b0}},
                                         idx_ok ? core_pc[reg_idx] : {PC_WIDTH{1'b0}}};
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_COMMIT: begin
                if (prog_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else if (tmo_cnt_q == TCW'(TIMEOUT - 1)) begin
                    // Core never answered: give up, flag it and release the bus.
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; cores are held in reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            valid_q   <= 1'b0;
            pcore_q   <= '0;
            paddr_q   <= '0;
            pdata_q   <= '0;
            stage_q   <= '0;
            run_q     <= '0;
            step_q    <= '0;
            rst_q     <= '1;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            valid_q   <= valid_d;
            pcore_q   <= pcore_d;
            paddr_q   <= paddr_d;
            pdata_q   <= pdata_d;
            stage_q   <= stage_d;
            run_q     <= run_d;
            step_q    <= step_d;
            rst_q     <= rst_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign prog_valid_o = valid_q;
    assign prog_core_o  = pcore_q;
    assign prog_addr_o  = paddr_q;
    assign prog_data_o  = pdata_q;
    assign core_run_o   = run_q;
    assign core_step_o  = step_q;
    assign core_rst_o   = rst_q;

endmodule

// File: tb/tb_wb_core_prog_ctrl.sv
// Directed testbench for wb_core_prog_ctrl with hand-computed expectations.
module tb_wb_core_prog_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        pvalid;
    logic        pready = 1'b0;
    logic [1:0]  pcore;
    logic [3:0]  paddr;
    logic [47:0] pdata;
    logic [3:0]  run;
    logic [3:0]  step;
    logic [3:0]  crst;
    logic [23:0] core_pc = {6'h2A, 6'h15, 6'h0C, 6'h03};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_core_prog_ctrl dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .prog_valid_o (pvalid),
        .prog_ready_i (pready),
        .prog_core_o  (pcore),
        .prog_addr_o  (paddr),
        .prog_data_o  (pdata),
        .core_run_o   (run),
        .core_step_o  (step),
        .core_rst_o   (crst),
        .core_pc_i    (core_pc)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last bus access.
    logic [31:0] x_rdata;
    int          x_lat;
    int          x_vcyc;
    logic [1:0]  x_pcore;
    logic [3:0]  x_paddr;
    logic [47:0] x_pdata;
    logic [3:0]  x_step_or;
    int          x_step_cnt;

    // One Wishbone access; the core raises ready after rdy_delay valid cycles.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int rdy_delay);
        logic got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        pready = 1'b0;
        got = 1'b0;
        x_lat = 0; x_vcyc = 0; x_rdata = '0; x_pcore = '0; x_paddr = '0; x_pdata = '0;
        x_step_or = '0; x_step_cnt = 0;
        while (!got && x_lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            x_lat++;
            if (step != 4'b0) begin
                x_step_cnt++;
                x_step_or = x_step_or | step;
            end
            if (pvalid) begin
                x_vcyc++;
                if (x_vcyc == 1) begin
                    x_pcore = pcore; x_paddr = paddr; x_pdata = pdata;
                end
                pready = (x_vcyc > rdy_delay);
            end
            if (ack) begin
                got = 1'b1;
                x_rdata = rdat;
                cyc = 1'b0; stb = 1'b0; we = 1'b0; pready = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; pready = 1'b0;
        check_eq("ack_seen", 64'(got), 64'd1);
        $display("xfer we=%0b adr=0x%08h dat=0x%08h lat=%0d rdata=0x%08h vcyc=%0d",
                 w, a, d, x_lat, x_rdata, x_vcyc);
    endtask

    initial begin
        // 1. Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_core_rst", 64'(crst), 64'hF);
        check_eq("rst_ack", 64'(ack), 64'd0);
        check_eq("rst_valid", 64'(pvalid), 64'd0);
        check_eq("rst_run", 64'(run), 64'd0);
        check_eq("rst_step", 64'(step), 64'd0);
        check_eq("rst_dat", 64'(rdat), 64'd0);
        rst_n = 1'b1;
        wb_xfer(1'b0, 32'h0000_4000, 32'h0, 4'hF, 0);
        check_eq("ctrl0_reset_read", 64'(x_rdata), 64'h4);
        check_eq("ctrl0_lat", 64'(x_lat), 64'd1);

        // 2. Instruction write, ready immediately
        wb_xfer(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0);
        check_eq("beat0_lat", 64'(x_lat), 64'd1);
        check_eq("beat0_novalid", 64'(x_vcyc), 64'd0);
        wb_xfer(1'b1, 32'h0000_0004, 32'h0000_1234, 4'hF, 0);
        check_eq("commit_lat", 64'(x_lat), 64'd2);
        check_eq("commit_vcyc", 64'(x_vcyc), 64'd1);
        check_eq("commit_data", 64'(x_pdata), 64'h1234_DEAD_BEEF);
        check_eq("commit_core", 64'(x_pcore), 64'd0);
        check_eq("commit_addr", 64'(x_paddr), 64'd0);
        // Core 2, instruction 5, beat1 with no new beat0: staging is reused.
        wb_xfer(1'b1, 32'h0000_012C, 32'h0000_ABCD, 4'hF, 0);
        check_eq("commit2_data", 64'(x_pdata), 64'hABCD_DEAD_BEEF);
        check_eq("commit2_core", 64'(x_pcore), 64'd2);
        check_eq("commit2_addr", 64'(x_paddr), 64'd5);

        // 3. Back-pressure, then timeout
        wb_xfer(1'b1, 32'h0000_0004, 32'h0000_5555, 4'hF, 3);
        check_eq("bp_lat", 64'(x_lat), 64'd5);
        check_eq("bp_vcyc", 64'(x_vcyc), 64'd4);
        wb_xfer(1'b0, 32'h0000_8000, 32'h0, 4'hF, 0);
        check_eq("bp_err_clear", 64'(x_rdata), 64'h0000_0003);
        wb_xfer(1'b1, 32'h0000_0004, 32'h0000_6666, 4'hF, 99);
        check_eq("tmo_lat", 64'(x_lat), 64'd16);
        check_eq("tmo_vcyc", 64'(x_vcyc), 64'd15);
        wb_xfer(1'b0, 32'h0000_8000, 32'h0, 4'hF, 0);
        check_eq("tmo_err_set", 64'(x_rdata), 64'h8000_0003);
        wb_xfer(1'b1, 32'h0000_8000, 32'h8000_0000, 4'hF, 0);
        wb_xfer(1'b0, 32'h0000_8000, 32'h0, 4'hF, 0);
        check_eq("err_cleared", 64'(x_rdata), 64'h0000_0003);

        // 4. Step
        wb_xfer(1'b1, 32'h0000_4008, 32'h0000_0002, 4'hF, 0);
        check_eq("step_mask", 64'(x_step_or), 64'h4);
        check_eq("step_cnt", 64'(x_step_cnt), 64'd1);
        @(negedge clk);
        check_eq("step_gone", 64'(step), 64'd0);
        check_eq("step_rst2_cleared", 64'(crst), 64'hB);
        wb_xfer(1'b1, 32'h0000_4008, 32'h0000_0001, 4'hF, 0);
        check_eq("run2_set", 64'(run), 64'h4);
        wb_xfer(1'b1, 32'h0000_4008, 32'h0000_0003, 4'hF, 0);
        check_eq("step_blocked_run", 64'(x_step_cnt), 64'd0);
        wb_xfer(1'b1, 32'h0000_4008, 32'h0000_0000, 4'hE, 0);
        wb_xfer(1'b0, 32'h0000_4008, 32'h0, 4'hF, 0);
        check_eq("sel0_low_ignored", 64'(x_rdata), 64'h1);
        wb_xfer(1'b1, 32'h0000_4008, 32'h0000_0000, 4'hF, 0);
        check_eq("run2_clear", 64'(run), 64'h0);
        wb_xfer(1'b1, 32'h0000_4008, 32'h0000_0003, 4'hF, 0);
        check_eq("step_same_write_run", 64'(x_step_cnt), 64'd0);
        check_eq("run2_after_03", 64'(run), 64'h4);

        // 5. Status / decode
        wb_xfer(1'b0, 32'h0000_800C, 32'h0, 4'hF, 0);
        check_eq("status_core3", 64'(x_rdata), 64'h0000_002A);
        wb_xfer(1'b0, 32'h0000_C000, 32'h0, 4'hF, 0);
        check_eq("region11_read", 64'(x_rdata), 64'h0);
        check_eq("region11_lat", 64'(x_lat), 64'd1);
        wb_xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0);
        check_eq("region0_read", 64'(x_rdata), 64'h0);
        check_eq("region0_read_novalid", 64'(x_vcyc), 64'd0);
        // Stray ready with no request outstanding.
        @(negedge clk);
        pready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("stray_ready_valid", 64'(pvalid), 64'd0);
        check_eq("stray_ready_ack", 64'(ack), 64'd0);
        pready = 1'b0;

        // 6. Reset during COMMIT
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0004; wdat = 32'h0000_7777; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check_eq("midc_valid_before", 64'(pvalid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midc_valid_after", 64'(pvalid), 64'd0);
        check_eq("midc_no_ack", 64'(ack), 64'd0);
        check_eq("midc_core_rst", 64'(crst), 64'hF);
        rst_n = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("xfer reset during commit, valid/ack dropped");
        wb_xfer(1'b0, 32'h0000_C000, 32'h0, 4'hF, 0);
        check_eq("post_rst_lat", 64'(x_lat), 64'd1);
        wb_xfer(1'b0, 32'h0000_4004, 32'h0, 4'hF, 0);
        check_eq("post_rst_ctrl1", 64'(x_rdata), 64'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
